// File: rtl/csa_10_8_sequencer.sv
// rtl/csa_10_8_sequencer.sv - batches up to ten 8-bit operands and sums them through a carry-save tree
// csa_10_8 reduces ten operands to sum/carry vectors with 3:2 compressors before one final add.

module csa_10_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  input  logic [7:0]  d,
  input  logic [7:0]  e,
  input  logic [7:0]  f,
  input  logic [7:0]  g,
  input  logic [7:0]  h,
  input  logic [7:0]  i,
  input  logic [7:0]  j,
  output logic [11:0] z
);

  // Each compressor keeps 12 bits; arithmetic is mod 4096 and the true total never exceeds 2550.
  function automatic logic [23:0] csa3(input logic [11:0] x, input logic [11:0] y,
                                       input logic [11:0] w);
    logic [11:0] s;
    logic [11:0] cy;
    s  = x ^ y ^ w;
    cy = ((x & y) | (x & w) | (y & w)) << 1;
    return {s, cy};
  endfunction

  logic [23:0] t0, t1, t2, t3, t4, t5, t6, t7;

  assign t0 = csa3({4'b0, a}, {4'b0, b}, {4'b0, c});
  assign t1 = csa3({4'b0, d}, {4'b0, e}, {4'b0, f});
  assign t2 = csa3({4'b0, g}, {4'b0, h}, {4'b0, i});
  assign t3 = csa3(t0[23:12], t0[11:0], t1[23:12]);
  assign t4 = csa3(t1[11:0], t2[23:12], t2[11:0]);
  assign t5 = csa3(t3[23:12], t3[11:0], t4[23:12]);
  assign t6 = csa3(t5[23:12], t5[11:0], t4[11:0]);
  assign t7 = csa3(t6[23:12], t6[11:0], {4'b0, j});
  assign z  = t7[23:12] + t7[11:0];

endmodule

module csa_10_8_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_sum,
  output logic [3:0]  out_count
);

  typedef enum logic [1:0] {FILL, COMPUTE, HOLD} state_t;

  state_t      state_q;
  logic [3:0]  count_q;
  logic [7:0]  slot_q [10];
  logic [11:0] out_sum_q;
  logic [3:0]  out_count_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic [11:0] csa_z;

  csa_10_8 u_csa (
    .a(slot_q[0]), .b(slot_q[1]), .c(slot_q[2]), .d(slot_q[3]), .e(slot_q[4]),
    .f(slot_q[5]), .g(slot_q[6]), .h(slot_q[7]), .i(slot_q[8]), .j(slot_q[9]),
    .z(csa_z)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= 4'd0;
      out_sum_q   <= 12'd0;
      out_count_q <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int k = 0; k < 10; k++) slot_q[k] <= 8'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid && in_ready_q) begin
            slot_q[count_q] <= in_data;
            count_q         <= count_q + 4'd1;
            if (count_q == 4'd9 || in_last) begin
              state_q    <= COMPUTE;
              in_ready_q <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          out_sum_q   <= csa_z;
          out_count_q <= count_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          // Slots are zeroed here so the next short batch sums only its own operands.
          if (out_ready) begin
            for (int k = 0; k < 10; k++) slot_q[k] <= 8'd0;
            count_q     <= 4'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= FILL;
          end
        end
        default: begin
          state_q    <= FILL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_csa_10_8_sequencer.sv
// tb/tb_csa_10_8_sequencer.sv - directed bench with a batch-level reference model for csa_10_8_sequencer
module tb_csa_10_8_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sum;
  logic [3:0]  out_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  csa_10_8_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: operands accumulate into a running sum; a closed batch
  // becomes visible one cycle later and stays until out_ready is seen.
  logic armed = 1'b0;
  bit   m_accept, m_pending, m_valid;
  int   acc_sum, acc_n, m_sum, m_cnt;

  always @(posedge clock) begin
    if (reset) begin
      armed = 1'b1;
      m_accept = 1; m_pending = 0; m_valid = 0;
      acc_sum = 0; acc_n = 0; m_sum = 0; m_cnt = 0;
    end else if (armed) begin
      if (m_accept) begin
        if (in_valid) begin
          acc_sum += int'(in_data);
          acc_n++;
          if (acc_n == 10 || in_last) begin
            m_accept = 0;
            m_pending = 1;
          end
        end
      end else if (m_pending) begin
        m_pending = 0;
        m_valid = 1;
        m_sum = acc_sum;
        m_cnt = acc_n;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
        m_accept = 1;
        acc_sum = 0;
        acc_n = 0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (armed) begin
      chk("in_ready", int'(in_ready), int'(m_accept));
      chk("out_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_count", int'(out_count), m_cnt);
      end
    end
  end

  logic [7:0] stim [10];
  int last_xfer;

  task automatic send_batch(input int n, input bit last_flag);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = stim[k];
      in_last  = (k == n - 1) ? last_flag : 1'b0;
      last_xfer = cyc;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic wait_result(input int exp_sum, input int exp_cnt, input int hold);
    bit seen = 0;
    int lat;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      bad++;
      total++;
      $display("FAIL result_timeout: out_valid stayed 0, expected sum %0d", exp_sum);
      return;
    end
    lat = cyc - last_xfer;
    chk("latency", lat, 2);
    chk("lit_sum", int'(out_sum), exp_sum);
    chk("lit_count", int'(out_count), exp_cnt);
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), exp_sum);
      chk("hold_ready", int'(in_ready), 0);
    end
    @(negedge clock);
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_ready", int'(in_ready), 1);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_ready", int'(in_ready), 1);

    // Full batch 1..10, out_ready held high during fill (must be ignored)
    for (int k = 0; k < 10; k++) stim[k] = 8'(k + 1);
    out_ready = 1'b1;
    send_batch(10, 1'b0);
    out_ready = 1'b0;
    wait_result(55, 10, 0);

    for (int k = 0; k < 10; k++) stim[k] = 8'd255;
    send_batch(10, 1'b0);
    wait_result(2550, 10, 1);

    stim[0] = 8'd3; stim[1] = 8'd14; stim[2] = 8'd5;
    send_batch(3, 1'b1);
    wait_result(22, 3, 5);

    stim[0] = 8'd7;
    send_batch(1, 1'b1);
    wait_result(7, 1, 0);

    // in_last on the tenth operand behaves as a full batch
    for (int k = 0; k < 10; k++) stim[k] = 8'(10 * k);
    send_batch(10, 1'b1);
    wait_result(450, 10, 2);

    // Reset mid-fill
    for (int k = 0; k < 4; k++) stim[k] = 8'd200;
    send_batch(4, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_ready", int'(in_ready), 1);
    for (int k = 0; k < 10; k++) stim[k] = 8'(k + 1);
    send_batch(10, 1'b0);
    wait_result(55, 10, 0);

    // Reset while a result is pending in HOLD
    stim[0] = 8'd40; stim[1] = 8'd2;
    send_batch(2, 1'b1);
    repeat (3) @(negedge clock);
    chk("pre_rst_valid", int'(out_valid), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("holdrst_valid", int'(out_valid), 0);
    chk("holdrst_sum", int'(out_sum), 0);
    stim[0] = 8'd9;
    send_batch(1, 1'b1);
    wait_result(9, 1, 0);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/csa_10_8_sequencer.md
CSA_10_8_SEQUENCER -- requirements
Module: csa_10_8_sequencer

Interface
REQ-001 Parameters: none; operand width is fixed at 8 bits, batch size at 10, and sum width at 12 bits.
REQ-002 clock  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 in_valid  input  1  Upstream operand valid.
REQ-005 in_ready  output  1  Block can accept an operand this cycle.
REQ-006 in_data  input  8  Unsigned operand.
REQ-007 in_last  input  1  Marks the final operand of a short batch; sampled only on an accepted transfer.
REQ-008 out_valid  output  1  Result valid.
REQ-009 out_ready  input  1  Downstream accepts the result.
REQ-010 out_sum  output  12  Unsigned sum of the batch operands.
REQ-011 out_count  output  4  Number of operands in the batch (1..10).

Function
REQ-012 The block SHALL contain ten 8-bit slot registers and instantiate one csa_10_8, wiring slot 0..9 to csa inputs a..j.
REQ-013 The block SHALL implement a three-state FSM: FILL, COMPUTE, HOLD.
REQ-014 Input transfers: an operand transfers on a cycle when in_valid=1 and in_ready=1; in_ready SHALL be 1 only in FILL.
REQ-015 FILL, on each transfer:
- write in_data into slot[count];
- increment count.
REQ-016 FILL SHALL go to COMPUTE after the transfer that makes count=10, or after any transfer with in_last=1, whichever comes first.
REQ-017 in_last=1 on the 10th operand SHALL behave identically to a full batch.
REQ-018 Unwritten slots SHALL hold 0, so a short batch sums only its accepted operands.
REQ-019 COMPUTE SHALL last exactly one cycle, during which the block:
- registers the csa z output into out_sum;
- registers count into out_count;
- transitions to HOLD.
REQ-020 Latency: out_valid SHALL assert exactly 2 cycles after the final operand transfer edge.
REQ-021 HOLD behaviour:
- out_valid=1;
- out_sum and out_count held stable until a cycle with out_ready=1.
REQ-022 On a HOLD cycle with out_ready=1, the block SHALL:
- clear all slots to 0;
- clear count to 0;
- deassert out_valid;
- return to FILL on the next cycle.
REQ-023 in_ready SHALL NOT assert in the same cycle as the result handshake; the first operand of the next batch is accepted no earlier than the following cycle.
REQ-024 Width rule: the maximum sum 10*255=2550 fits in 12 bits; no overflow or saturation logic is required.
REQ-025 out_valid SHALL be 0 in FILL and COMPUTE.
REQ-026 in_valid, in_data and in_last SHALL be ignored outside FILL.
REQ-027 out_ready SHALL be ignored outside HOLD.
REQ-028 A reset asserted in any state, including mid-fill or during HOLD, SHALL discard the partial batch or pending result.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL:
- set state to FILL;
- clear count to 0;
- clear all slots to 0;
- set out_sum=0, out_count=0, out_valid=0.
REQ-030 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-031 No output SHALL depend on power-up state once one reset cycle has been applied.

Verification
REQ-032 Reset: hold reset 2 cycles, then release -> out_valid=0, out_sum=0, out_count=0, in_ready=1.
REQ-033 Full batch: operands 1..10 back-to-back with in_last=0 -> in_ready drops after the 10th transfer; out_valid rises 2 cycles later with out_sum=55, out_count=10.
REQ-034 Maximum batch: ten operands of 255 -> out_sum=2550 (0x9F6), out_count=10.
REQ-035 Short batch: operands 3, 14, 5 with in_last on 5 -> out_sum=22, out_count=3.
REQ-036 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_sum and out_count stay stable and in_ready=0. Then pulse out_ready, and send one operand 7 with in_last -> out_sum=7, confirming the slots were cleared.
REQ-037 Reset mid-fill: accept 4 operands of 200, then pulse reset, then send operands 1..10 -> out_sum=55, out_count=10.
